// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter block.
// Contents: PC width, increment, default boot/trap vectors, FSM state type.
package pc_pkg;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned RETIRE_W = 64;

  localparam logic [PC_W-1:0] PC_INC               = 32'd4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pc_retire_counter.sv
// Retired-instruction counter, built only when PC_RETIRE_COUNT_EN is defined.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   retire_i    - one instruction retired on this edge
//   count_o     - running 64-bit count, wraps at 2^64
module pc_retire_counter
  import pc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                retire_i,
  output logic [RETIRE_W-1:0] count_o
);

  logic [RETIRE_W-1:0] count_q;
  logic [RETIRE_W-1:0] count_d;

  // Next count: advance by one per retire, natural wrap.
  always_comb begin
    count_d = count_q;
    if (retire_i) begin
      count_d = count_q + RETIRE_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_register.sv
// Architectural program counter with boot, stall, debug halt/resume and
// misaligned-target trapping. Optional retire counter under PC_RETIRE_COUNT_EN.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   next_pc        - target from the next-PC mux
//   stall          - hold PC this cycle
//   halt_req       - debug halt request (level)
//   resume         - debug resume pulse, honoured only while halted
//   pc, pc_plus4   - current PC and PC+4 (pc_plus4 is combinational)
//   fetch_valid    - pc is a valid fetch address
//   halted         - core is in debug halt
//   trap           - one-cycle pulse when a misaligned target was taken
//   trap_addr      - offending target of the most recent trap
//   retire_count   - (PC_RETIRE_COUNT_EN only) count of normal PC advances
module pc_register
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [PC_W-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [PC_W-1:0] next_pc,
  input  logic                   stall,
  input  logic                   halt_req,
  input  logic                   resume,
  output logic signed [PC_W-1:0] pc,
  output logic signed [PC_W-1:0] pc_plus4,
  output logic                   fetch_valid,
  output logic                   halted,
  output logic                   trap,
  output logic        [PC_W-1:0] trap_addr
`ifdef PC_RETIRE_COUNT_EN
  ,
  output logic    [RETIRE_W-1:0] retire_count
`endif
);

  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'((64'd1 << ALIGN_BITS) - 64'd1);

  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] trap_addr_q, trap_addr_d;
  logic            trap_q, trap_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] next_pc_u;
  logic            misaligned_c;

  // All PC arithmetic is unsigned regardless of the port type.
  assign next_pc_u    = $unsigned(next_pc);
  assign misaligned_c = (next_pc_u & ALIGN_MASK) != '0;

  // Next-state, next-PC and registered-output decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    trap_addr_d = trap_addr_q;
    trap_d      = 1'b0;

    case (state_q)
      BOOT: state_d = halt_req ? HALT : RUN;
      RUN: begin
        // Halt and stall both suppress the alignment check.
        if (halt_req) begin
          state_d = HALT;
        end else if (!stall) begin
          if (misaligned_c) begin
            pc_d        = TRAP_VECTOR;
            trap_addr_d = next_pc_u;
            trap_d      = 1'b1;
            state_d     = TRAP;
          end else begin
            pc_d = next_pc_u;
          end
        end
      end
      TRAP: begin
        // PC stays on TRAP_VECTOR so the first RUN cycle fetches the handler.
        if (halt_req) begin
          state_d = HALT;
        end else if (!stall) begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (resume && !halt_req) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    fetch_valid_d = (state_d == RUN) || (state_d == TRAP);
    halted_d      = (state_d == HALT);
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      trap_addr_q   <= '0;
      trap_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      trap_addr_q   <= trap_addr_d;
      trap_q        <= trap_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + PC_INC;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;
  assign trap        = trap_q;
  assign trap_addr   = trap_addr_q;

`ifdef PC_RETIRE_COUNT_EN
  logic retire_c;

  // Only a normal advance to next_pc counts as a retire.
  assign retire_c = (state_q == RUN) && !halt_req && !stall && !misaligned_c;

  pc_retire_counter u_retire_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .retire_i (retire_c),
    .count_o  (retire_count)
  );
`endif

endmodule

// File: tb/tb_pc_register.sv
// Bench for pc_register: directed steps followed by random stimulus, all
// checked against a behavioural PC model.
module tb_pc_register;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [31:0] next_pc = '0;
  logic               stall = 1'b0;
  logic               halt_req = 1'b0;
  logic               resume = 1'b0;
  logic signed [31:0] pc;
  logic signed [31:0] pc_plus4;
  logic               fetch_valid;
  logic               halted;
  logic               trap;
  logic        [31:0] trap_addr;
  logic        [31:0] pc_u;
  logic        [31:0] pc_plus4_u;
`ifdef PC_RETIRE_COUNT_EN
  logic        [63:0] retire_count;
`endif

  assign pc_u       = pc;
  assign pc_plus4_u = pc_plus4;

  pc_register dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .stall       (stall),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .trap        (trap),
    .trap_addr   (trap_addr)
`ifdef PC_RETIRE_COUNT_EN
    ,
    .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: the mode the core is in, plus the visible values.
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_TRAP = 2;
  localparam int M_HALT = 3;

  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_taddr;
  logic        m_trap;
  logic [63:0] m_ret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_BOOT;
    m_pc    = 32'h0;
    m_taddr = 32'h0;
    m_trap  = 1'b0;
    m_ret   = 64'd0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held across it.
  task automatic model_edge();
    logic [31:0] np;
    np     = next_pc;
    m_trap = 1'b0;
    case (m_mode)
      M_BOOT: m_mode = halt_req ? M_HALT : M_RUN;
      M_RUN: begin
        if (halt_req) m_mode = M_HALT;
        else if (!stall) begin
          if ((np % 32'd4) != 32'd0) begin
            m_pc    = 32'h100;
            m_taddr = np;
            m_trap  = 1'b1;
            m_mode  = M_TRAP;
          end else begin
            m_pc  = np;
            m_ret = m_ret + 64'd1;
          end
        end
      end
      M_TRAP: begin
        if (halt_req) m_mode = M_HALT;
        else if (!stall) m_mode = M_RUN;
      end
      default: begin
        if (resume && !halt_req) m_mode = M_RUN;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 64'(pc_u), 64'(m_pc));
    chk({tag, ".pc_plus4"}, 64'(pc_plus4_u), 64'(32'(m_pc + 32'd4)));
    chk({tag, ".fetch_valid"}, 64'(fetch_valid), 64'((m_mode == M_RUN) || (m_mode == M_TRAP)));
    chk({tag, ".halted"}, 64'(halted), 64'(m_mode == M_HALT));
    chk({tag, ".trap"}, 64'(trap), 64'(m_trap));
    chk({tag, ".trap_addr"}, 64'(trap_addr), 64'(m_taddr));
`ifdef PC_RETIRE_COUNT_EN
    chk({tag, ".retire_count"}, retire_count, m_ret);
`endif
  endtask

  // Drive inputs, take one edge, check 1 time unit after it.
  task automatic step(input string tag, input logic [31:0] np, input logic st,
                      input logic hr, input logic rs);
    next_pc  = np;
    stall    = st;
    halt_req = hr;
    resume   = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".asserted"});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all({tag, ".released"});
  endtask

  initial begin
    logic hr_r;
    logic [31:0] np_r;

    // 1. Reset boot
    next_pc = 32'h40;
    #2;
    do_reset("t1_reset");
    chk("t1_boot_pc", 64'(pc_u), 64'h0);
    chk("t1_boot_fv", 64'(fetch_valid), 64'h0);
    step("t1_boot_edge", 32'h40, 1'b0, 1'b0, 1'b0);
    step("t1_first", 32'h40, 1'b0, 1'b0, 1'b0);
    chk("t1_pc40", 64'(pc_u), 64'h40);
    chk("t1_pc44", 64'(pc_plus4_u), 64'h44);

    // 2. Sequential, forward and backward branches
    step("t2_04", 32'h04, 1'b0, 1'b0, 1'b0);
    step("t2_08", 32'h08, 1'b0, 1'b0, 1'b0);
    step("t2_1000", 32'h1000, 1'b0, 1'b0, 1'b0);
    chk("t2_pc1000", 64'(pc_u), 64'h1000);
    step("t2_204", 32'h204, 1'b0, 1'b0, 1'b0);
    step("t2_back", 32'h100, 1'b0, 1'b0, 1'b0);
    chk("t2_pc100", 64'(pc_u), 64'h100);

    // 3. Stall
    step("t3_10", 32'h10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("t3_stall", 32'h200, 1'b1, 1'b0, 1'b0);
      chk("t3_hold", 64'(pc_u), 64'h10);
    end
    step("t3_go", 32'h200, 1'b0, 1'b0, 1'b0);
    chk("t3_pc200", 64'(pc_u), 64'h200);

    // 4. Misaligned target
    step("t4_mis", 32'hABE, 1'b0, 1'b0, 1'b0);
    chk("t4_trap", 64'(trap), 64'h1);
    chk("t4_pc", 64'(pc_u), 64'h100);
    chk("t4_taddr", 64'(trap_addr), 64'hABE);
    step("t4_exit", 32'h104, 1'b0, 1'b0, 1'b0);
    chk("t4_trap_low", 64'(trap), 64'h0);
    step("t4_run", 32'h104, 1'b0, 1'b0, 1'b0);
    chk("t4_pc104", 64'(pc_u), 64'h104);

    // 5. Halt / resume
    step("t5_20", 32'h20, 1'b0, 1'b0, 1'b0);
    step("t5_halt", 32'h80, 1'b0, 1'b1, 1'b0);
    chk("t5_halted", 64'(halted), 64'h1);
    chk("t5_pc", 64'(pc_u), 64'h20);
    step("t5_ign", 32'h80, 1'b0, 1'b1, 1'b1);
    chk("t5_ign_halted", 64'(halted), 64'h1);
    step("t5_resume", 32'h80, 1'b0, 1'b0, 1'b1);
    chk("t5_run_fv", 64'(fetch_valid), 64'h1);
    chk("t5_run_pc", 64'(pc_u), 64'h20);

    // 6. Wrap, then reset in the middle of a trap
    step("t6_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    chk("t6_plus4", 64'(pc_plus4_u), 64'h0);
    step("t6_mis", 32'h3, 1'b0, 1'b0, 1'b0);
    do_reset("t6_reset");
    chk("t6_pc_rst", 64'(pc_u), 64'h0);
    chk("t6_trap_rst", 64'(trap), 64'h0);

    // Random stimulus
    hr_r = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_reset");
      end
      np_r = $urandom;
      if ($urandom_range(0, 3) != 0) np_r = np_r & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) hr_r = ~hr_r;
      step("rnd", np_r, ($urandom_range(0, 3) == 0), hr_r, ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
